// File: rtl/cu_pkg.sv
// Shared encodings for the multi-cycle control sequencer: opcodes, opcode
// classes, top-level states and the bit layout of the packed control word.
package cu_pkg;

    localparam logic [4:0] OP_LD   = 5'd0;
    localparam logic [4:0] OP_LDI  = 5'd1;
    localparam logic [4:0] OP_ST   = 5'd2;
    localparam logic [4:0] OP_ADD  = 5'd3;
    localparam logic [4:0] OP_SUB  = 5'd4;
    localparam logic [4:0] OP_AND  = 5'd5;
    localparam logic [4:0] OP_OR   = 5'd6;
    localparam logic [4:0] OP_SHR  = 5'd7;
    localparam logic [4:0] OP_SHRA = 5'd8;
    localparam logic [4:0] OP_SHL  = 5'd9;
    localparam logic [4:0] OP_ROR  = 5'd10;
    localparam logic [4:0] OP_ROL  = 5'd11;
    localparam logic [4:0] OP_ADDI = 5'd12;
    localparam logic [4:0] OP_ANDI = 5'd13;
    localparam logic [4:0] OP_ORI  = 5'd14;
    localparam logic [4:0] OP_MUL  = 5'd15;
    localparam logic [4:0] OP_DIV  = 5'd16;
    localparam logic [4:0] OP_NEG  = 5'd17;
    localparam logic [4:0] OP_NOT  = 5'd18;
    localparam logic [4:0] OP_BR   = 5'd19;
    localparam logic [4:0] OP_JR   = 5'd20;
    localparam logic [4:0] OP_JAL  = 5'd21;
    localparam logic [4:0] OP_IN   = 5'd22;
    localparam logic [4:0] OP_OUT  = 5'd23;
    localparam logic [4:0] OP_MFHI = 5'd24;
    localparam logic [4:0] OP_MFLO = 5'd25;
    localparam logic [4:0] OP_NOP  = 5'd26;
    localparam logic [4:0] OP_HALT = 5'd27;

    typedef enum logic [4:0] {
        CLS_LD, CLS_LDI, CLS_ST, CLS_ALU_RR, CLS_ALU_RI, CLS_MULDIV, CLS_UNARY,
        CLS_BR, CLS_JR, CLS_JAL, CLS_IN, CLS_OUT, CLS_MFHI, CLS_MFLO, CLS_NOP,
        CLS_HALT, CLS_ILLEGAL
    } op_class_e;

    typedef enum logic [2:0] {
        ST_RESET, ST_FETCH, ST_EXEC, ST_PAUSED, ST_HALTED, ST_FAULT
    } top_state_e;

    localparam int CW_PCOUT     = 0;
    localparam int CW_MARIN     = 1;
    localparam int CW_INCPC     = 2;
    localparam int CW_ZIN       = 3;
    localparam int CW_ZLOWOUT   = 4;
    localparam int CW_ZHIGHOUT  = 5;
    localparam int CW_PCIN      = 6;
    localparam int CW_MD_READ   = 7;
    localparam int CW_MDRIN     = 8;
    localparam int CW_MDROUT    = 9;
    localparam int CW_IRIN      = 10;
    localparam int CW_GRA       = 11;
    localparam int CW_GRB       = 12;
    localparam int CW_GRC       = 13;
    localparam int CW_ROUT      = 14;
    localparam int CW_RIN       = 15;
    localparam int CW_BAOUT     = 16;
    localparam int CW_YIN       = 17;
    localparam int CW_ALU_EN    = 18;
    localparam int CW_CSIGNOUT  = 19;
    localparam int CW_LOIN      = 20;
    localparam int CW_HIIN      = 21;
    localparam int CW_LOOUT     = 22;
    localparam int CW_HIOUT     = 23;
    localparam int CW_CONIN     = 24;
    localparam int CW_INPORTOUT = 25;
    localparam int CW_OUTPORTIN = 26;
    localparam int CW_WRITE     = 27;
    localparam int CW_W         = 28;

    // One-hot masks so micro-steps read as a list of asserted signals.
    localparam logic [CW_W-1:0] M_PCOUT     = CW_W'(1) << CW_PCOUT;
    localparam logic [CW_W-1:0] M_MARIN     = CW_W'(1) << CW_MARIN;
    localparam logic [CW_W-1:0] M_INCPC     = CW_W'(1) << CW_INCPC;
    localparam logic [CW_W-1:0] M_ZIN       = CW_W'(1) << CW_ZIN;
    localparam logic [CW_W-1:0] M_ZLOWOUT   = CW_W'(1) << CW_ZLOWOUT;
    localparam logic [CW_W-1:0] M_ZHIGHOUT  = CW_W'(1) << CW_ZHIGHOUT;
    localparam logic [CW_W-1:0] M_PCIN      = CW_W'(1) << CW_PCIN;
    localparam logic [CW_W-1:0] M_MD_READ   = CW_W'(1) << CW_MD_READ;
    localparam logic [CW_W-1:0] M_MDRIN     = CW_W'(1) << CW_MDRIN;
    localparam logic [CW_W-1:0] M_MDROUT    = CW_W'(1) << CW_MDROUT;
    localparam logic [CW_W-1:0] M_IRIN      = CW_W'(1) << CW_IRIN;
    localparam logic [CW_W-1:0] M_GRA       = CW_W'(1) << CW_GRA;
    localparam logic [CW_W-1:0] M_GRB       = CW_W'(1) << CW_GRB;
    localparam logic [CW_W-1:0] M_GRC       = CW_W'(1) << CW_GRC;
    localparam logic [CW_W-1:0] M_ROUT      = CW_W'(1) << CW_ROUT;
    localparam logic [CW_W-1:0] M_RIN       = CW_W'(1) << CW_RIN;
    localparam logic [CW_W-1:0] M_BAOUT     = CW_W'(1) << CW_BAOUT;
    localparam logic [CW_W-1:0] M_YIN       = CW_W'(1) << CW_YIN;
    localparam logic [CW_W-1:0] M_ALU_EN    = CW_W'(1) << CW_ALU_EN;
    localparam logic [CW_W-1:0] M_CSIGNOUT  = CW_W'(1) << CW_CSIGNOUT;
    localparam logic [CW_W-1:0] M_LOIN      = CW_W'(1) << CW_LOIN;
    localparam logic [CW_W-1:0] M_HIIN      = CW_W'(1) << CW_HIIN;
    localparam logic [CW_W-1:0] M_LOOUT     = CW_W'(1) << CW_LOOUT;
    localparam logic [CW_W-1:0] M_HIOUT     = CW_W'(1) << CW_HIOUT;
    localparam logic [CW_W-1:0] M_CONIN     = CW_W'(1) << CW_CONIN;
    localparam logic [CW_W-1:0] M_INPORTOUT = CW_W'(1) << CW_INPORTOUT;
    localparam logic [CW_W-1:0] M_OUTPORTIN = CW_W'(1) << CW_OUTPORTIN;
    localparam logic [CW_W-1:0] M_WRITE     = CW_W'(1) << CW_WRITE;

    function automatic logic [2:0] last_step(op_class_e cls);
        case (cls)
            CLS_LD, CLS_ST:                  return 3'd7;
            CLS_MULDIV, CLS_BR:              return 3'd6;
            CLS_ALU_RR, CLS_ALU_RI, CLS_LDI: return 3'd5;
            CLS_UNARY, CLS_JAL:              return 3'd4;
            default:                         return 3'd3;
        endcase
    endfunction

    function automatic logic is_wait_step(op_class_e cls, logic [2:0] step);
        return (cls == CLS_LD && step == 3'd6) || (cls == CLS_ST && step == 3'd7);
    endfunction

endpackage

// File: rtl/multicycle_control_seq_if.sv
// Datapath-facing bundle of the control sequencer; master drives the
// instruction/status inputs, slave is the sequencer itself.
interface multicycle_control_seq_if
    import cu_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int OPC_W  = 5
) ();

    logic              stop;
    logic [DATA_W-1:0] ir;
    logic              con_ff;
    logic              mem_ready;
    logic [CW_W-1:0]   ctrl;
    logic [OPC_W-1:0]  alu_op;
    logic              run;
    logic              clear;
    logic              fault;

    modport master (
        output stop, ir, con_ff, mem_ready,
        input  ctrl, alu_op, run, clear, fault
    );

    modport slave (
        input  stop, ir, con_ff, mem_ready,
        output ctrl, alu_op, run, clear, fault
    );

endinterface

// File: rtl/cu_opcode_decoder.sv
// Combinational opcode classifier; anything outside the defined map is illegal.
module cu_opcode_decoder
    import cu_pkg::*;
#(
    parameter int OPC_W = 5
) (
    input  logic [OPC_W-1:0] opcode_i,
    output op_class_e        class_o,
    output logic             illegal_o
);

    logic [4:0] opc5;

    // NOTE: every output gets a default before the case so no latch is inferred.
    always_comb begin
        class_o = CLS_ILLEGAL;
        opc5    = 5'(opcode_i);
        if (opcode_i <= OPC_W'(OP_HALT)) begin
            case (opc5)
                OP_LD:                               class_o = CLS_LD;
                OP_LDI:                              class_o = CLS_LDI;
                OP_ST:                               class_o = CLS_ST;
                OP_ADD, OP_SUB, OP_AND, OP_OR,
                OP_SHR, OP_SHRA, OP_SHL, OP_ROR,
                OP_ROL:                              class_o = CLS_ALU_RR;
                OP_ADDI, OP_ANDI, OP_ORI:            class_o = CLS_ALU_RI;
                OP_MUL, OP_DIV:                      class_o = CLS_MULDIV;
                OP_NEG, OP_NOT:                      class_o = CLS_UNARY;
                OP_BR:                               class_o = CLS_BR;
                OP_JR:                               class_o = CLS_JR;
                OP_JAL:                              class_o = CLS_JAL;
                OP_IN:                               class_o = CLS_IN;
                OP_OUT:                              class_o = CLS_OUT;
                OP_MFHI:                             class_o = CLS_MFHI;
                OP_MFLO:                             class_o = CLS_MFLO;
                OP_NOP:                              class_o = CLS_NOP;
                OP_HALT:                             class_o = CLS_HALT;
                default:                             class_o = CLS_ILLEGAL;
            endcase
        end
    end

    assign illegal_o = (class_o == CLS_ILLEGAL);

endmodule

// File: rtl/multicycle_control_seq.sv
// Fetch/decode/execute control sequencer with memory wait states, timeout,
// illegal-opcode fault, stop/resume and halt. Outputs are Moore-decoded.
module multicycle_control_seq
    import cu_pkg::*;
#(
    parameter int DATA_W      = 32,
    parameter int OPC_W       = 5,
    parameter int OPC_LSB     = 27,
    parameter int MEM_TIMEOUT = 15
) (
    input logic                     clock,
    input logic                     reset,
    multicycle_control_seq_if.slave bus
);

    localparam logic [7:0] WAIT_LIMIT = 8'(MEM_TIMEOUT - 1);

    top_state_e       state_q, state_d;
    logic [2:0]       step_q,  step_d;
    op_class_e        cls_q,   cls_d;
    logic [OPC_W-1:0] opc_q,   opc_d;
    logic [7:0]       wait_q,  wait_d;

    logic [DATA_W-1:0] ir_word;
    logic [OPC_W-1:0]  opcode;
    op_class_e         dec_cls;
    logic              dec_illegal;
    logic              in_wait;
    logic              mem_hold;
    logic [CW_W-1:0]   cw;
    logic              unused_ir;

    // Operand fields belong to the datapath; only the opcode is decoded here.
    assign ir_word   = bus.ir;
    assign opcode    = ir_word[OPC_LSB +: OPC_W];
    assign unused_ir = ^ir_word;

    cu_opcode_decoder #(.OPC_W(OPC_W)) u_decoder (
        .opcode_i  (opcode),
        .class_o   (dec_cls),
        .illegal_o (dec_illegal)
    );

    assign in_wait  = (state_q == ST_FETCH && step_q == 3'd1) ||
                      (state_q == ST_EXEC && is_wait_step(cls_q, step_q));
    assign mem_hold = in_wait && !bus.mem_ready;

    always_comb begin
        state_d = state_q;
        step_d  = step_q;
        cls_d   = cls_q;
        opc_d   = opc_q;
        wait_d  = '0;
        unique case (state_q)
            ST_RESET: begin
                state_d = ST_FETCH;
                step_d  = 3'd0;
            end
            ST_FETCH, ST_EXEC: begin
                if (mem_hold) begin
                    if (wait_q == WAIT_LIMIT) state_d = ST_FAULT;
                    else                      wait_d  = wait_q + 8'd1;
                end else if (state_q == ST_FETCH && step_q == 3'd2) begin
                    opc_d  = opcode;
                    cls_d  = dec_cls;
                    step_d = 3'd3;
                    if (dec_illegal)              state_d = ST_FAULT;
                    else if (dec_cls == CLS_HALT) state_d = ST_HALTED;
                    else                          state_d = ST_EXEC;
                end else if (state_q == ST_EXEC && step_q == last_step(cls_q)) begin
                    // Instruction boundary: the only point where stop is honoured.
                    step_d  = 3'd0;
                    state_d = bus.stop ? ST_PAUSED : ST_FETCH;
                end else begin
                    step_d = step_q + 3'd1;
                end
            end
            ST_PAUSED: begin
                if (!bus.stop) begin
                    state_d = ST_FETCH;
                    step_d  = 3'd0;
                end
            end
            default: ;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of the others.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q <= ST_RESET;
            step_q  <= 3'd0;
            cls_q   <= CLS_NOP;
            opc_q   <= '0;
            wait_q  <= '0;
        end else begin
            state_q <= state_d;
            step_q  <= step_d;
            cls_q   <= cls_d;
            opc_q   <= opc_d;
            wait_q  <= wait_d;
        end
    end

    always_comb begin
        cw = '0;
        unique case (state_q)
            ST_FETCH: begin
                case (step_q)
                    3'd0:    cw = M_PCOUT | M_MARIN | M_INCPC | M_ZIN;
                    3'd1:    cw = M_ZLOWOUT | M_PCIN | M_MD_READ | M_MDRIN;
                    3'd2:    cw = M_MDROUT | M_IRIN;
                    default: cw = '0;
                endcase
            end
            ST_EXEC: begin
                unique case (cls_q)
                    CLS_ALU_RR, CLS_ALU_RI: begin
                        case (step_q)
                            3'd3:    cw = M_GRB | M_ROUT | M_YIN;
                            3'd4:    cw = M_ALU_EN | M_ZIN |
                                          ((cls_q == CLS_ALU_RI) ? M_CSIGNOUT : (M_GRC | M_ROUT));
                            3'd5:    cw = M_ZLOWOUT | M_GRA | M_RIN;
                            default: cw = '0;
                        endcase
                    end
                    CLS_MULDIV: begin
                        case (step_q)
                            3'd3:    cw = M_GRA | M_ROUT | M_YIN;
                            3'd4:    cw = M_GRB | M_ROUT | M_ALU_EN | M_ZIN;
                            3'd5:    cw = M_ZLOWOUT | M_LOIN;
                            3'd6:    cw = M_ZHIGHOUT | M_HIIN;
                            default: cw = '0;
                        endcase
                    end
                    CLS_UNARY: begin
                        case (step_q)
                            3'd3:    cw = M_GRB | M_ROUT | M_ALU_EN | M_ZIN;
                            3'd4:    cw = M_ZLOWOUT | M_GRA | M_RIN;
                            default: cw = '0;
                        endcase
                    end
                    CLS_LD, CLS_LDI, CLS_ST: begin
                        case (step_q)
                            3'd3:    cw = M_GRB | M_BAOUT | M_YIN;
                            3'd4:    cw = M_CSIGNOUT | M_ALU_EN | M_ZIN;
                            3'd5:    cw = M_ZLOWOUT | ((cls_q == CLS_LDI) ? (M_GRA | M_RIN) : M_MARIN);
                            3'd6:    cw = (cls_q == CLS_LD) ? (M_MD_READ | M_MDRIN)
                                                            : (M_GRA | M_ROUT | M_MDRIN);
                            3'd7:    cw = (cls_q == CLS_LD) ? (M_MDROUT | M_GRA | M_RIN) : M_WRITE;
                            default: cw = '0;
                        endcase
                    end
                    CLS_BR: begin
                        case (step_q)
                            3'd3:    cw = M_GRA | M_ROUT | M_CONIN;
                            3'd4:    cw = M_PCOUT | M_YIN;
                            3'd5:    cw = M_CSIGNOUT | M_ALU_EN | M_ZIN;
                            3'd6:    cw = bus.con_ff ? (M_ZLOWOUT | M_PCIN) : '0;
                            default: cw = '0;
                        endcase
                    end
                    CLS_JAL:  cw = (step_q == 3'd3) ? (M_PCOUT | M_GRB | M_RIN) : (M_GRA | M_ROUT | M_PCIN);
                    CLS_JR:   cw = M_GRA | M_ROUT | M_PCIN;
                    CLS_IN:   cw = M_INPORTOUT | M_GRA | M_RIN;
                    CLS_OUT:  cw = M_GRA | M_ROUT | M_OUTPORTIN;
                    CLS_MFHI: cw = M_HIOUT | M_GRA | M_RIN;
                    CLS_MFLO: cw = M_LOOUT | M_GRA | M_RIN;
                    default:  cw = '0;
                endcase
            end
            default: cw = '0;
        endcase
    end

    // Address arithmetic for memory and branch classes always uses add.
    assign bus.alu_op = !cw[CW_ALU_EN] ? '0 :
                        (cls_q inside {CLS_LD, CLS_LDI, CLS_ST, CLS_BR}) ? OPC_W'(OP_ADD) : opc_q;
    assign bus.ctrl   = cw;
    assign bus.run    = (state_q == ST_FETCH) || (state_q == ST_EXEC);
    assign bus.clear  = (state_q == ST_RESET);
    assign bus.fault  = (state_q == ST_FAULT);

endmodule

// File: tb/tb_multicycle_control_seq.sv
// Directed bench for multicycle_control_seq: walks instruction classes, wait
// states, timeout, stop/resume, halt, illegal opcode and mid-instruction reset.
module tb_multicycle_control_seq;
    import cu_pkg::*;

    logic clock = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    multicycle_control_seq_if #(.DATA_W(32), .OPC_W(5)) bus ();

    multicycle_control_seq #(
        .DATA_W(32), .OPC_W(5), .OPC_LSB(27), .MEM_TIMEOUT(15)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    localparam logic [CW_W-1:0] W_T0 = M_PCOUT | M_MARIN | M_INCPC | M_ZIN;
    localparam logic [CW_W-1:0] W_T1 = M_ZLOWOUT | M_PCIN | M_MD_READ | M_MDRIN;
    localparam logic [CW_W-1:0] W_T2 = M_MDROUT | M_IRIN;

    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic check_cw(input string tag, input logic [CW_W-1:0] exp);
        check(tag, 32'(bus.ctrl), 32'(exp));
    endtask

    task automatic check_st(input string tag, input logic run, input logic clear, input logic fault);
        check({tag, "_run"},   32'(bus.run),   32'(run));
        check({tag, "_clear"}, 32'(bus.clear), 32'(clear));
        check({tag, "_fault"}, 32'(bus.fault), 32'(fault));
    endtask

    // Starts in T0 with mem_ready=1; returns just after the decode edge.
    task automatic fetch(input string tag, input logic [4:0] opc);
        check_cw({tag, "_t0"}, W_T0);
        bus.ir = {opc, 27'h0123456};
        cyc();
        check_cw({tag, "_t1"}, W_T1);
        cyc();
        check_cw({tag, "_t2"}, W_T2);
        cyc();
    endtask

    task automatic do_reset();
        reset = 1'b0;
        bus.mem_ready = 1'b1;
        cyc();
        reset = 1'b1;
        cyc();
    endtask

    initial begin
        reset         = 1'b0;
        bus.stop      = 1'b0;
        bus.ir        = '0;
        bus.con_ff    = 1'b0;
        bus.mem_ready = 1'b1;
        cyc();
        cyc();
        check_cw("rst_ctrl", '0);
        check("rst_aluop", 32'(bus.alu_op), 32'd0);
        check_st("rst", 1'b0, 1'b1, 1'b0);
        reset = 1'b1;
        cyc();
        check_st("t0", 1'b1, 1'b0, 1'b0);

        // add r1,r2,r3
        fetch("add", 5'd3);
        check_cw("add_t3", M_GRB | M_ROUT | M_YIN);
        check("add_t3_aluop", 32'(bus.alu_op), 32'd0);
        cyc();
        check_cw("add_t4", M_GRC | M_ROUT | M_ALU_EN | M_ZIN);
        check("add_t4_aluop", 32'(bus.alu_op), 32'd3);
        cyc();
        check_cw("add_t5", M_ZLOWOUT | M_GRA | M_RIN);
        cyc();

        // addi: immediate operand replaces Grc Rout
        fetch("addi", 5'd12);
        cyc();
        check_cw("addi_t4", M_CSIGNOUT | M_ALU_EN | M_ZIN);
        check("addi_t4_aluop", 32'(bus.alu_op), 32'd12);
        cyc();
        cyc();

        // ld with mem_ready low for 4 edges at T6
        fetch("ld", 5'd0);
        check_cw("ld_t3", M_GRB | M_BAOUT | M_YIN);
        cyc();
        check_cw("ld_t4", M_CSIGNOUT | M_ALU_EN | M_ZIN);
        check("ld_t4_aluop", 32'(bus.alu_op), 32'd3);
        cyc();
        check_cw("ld_t5", M_ZLOWOUT | M_MARIN);
        bus.mem_ready = 1'b0;
        cyc();
        for (int i = 0; i < 5; i++) begin
            check_cw($sformatf("ld_t6_hold%0d", i), M_MD_READ | M_MDRIN);
            if (i == 4) bus.mem_ready = 1'b1;
            cyc();
        end
        check_cw("ld_t7", M_MDROUT | M_GRA | M_RIN);
        check("ld_t7_fault", 32'(bus.fault), 32'd0);
        cyc();

        // st with mem_ready stuck low -> timeout fault 15 cycles into T7
        fetch("st", 5'd2);
        cyc();
        cyc();
        check_cw("st_t5", M_ZLOWOUT | M_MARIN);
        cyc();
        check_cw("st_t6", M_GRA | M_ROUT | M_MDRIN);
        bus.mem_ready = 1'b0;
        cyc();
        for (int i = 0; i < 15; i++) begin
            check_cw($sformatf("st_t7_hold%0d", i), M_WRITE);
            if (i == 14) check("st_t7_last_fault", 32'(bus.fault), 32'd0);
            cyc();
        end
        check_st("st_timeout", 1'b0, 1'b0, 1'b1);
        check_cw("st_timeout_ctrl", '0);
        bus.mem_ready = 1'b1;
        cyc();
        cyc();
        check_st("st_sticky", 1'b0, 1'b0, 1'b1);
        check_cw("st_sticky_ctrl", '0);
        reset = 1'b0;
        cyc();
        check_st("st_reset", 1'b0, 1'b1, 1'b0);
        reset = 1'b1;
        cyc();

        // br not taken, then taken
        bus.con_ff = 1'b0;
        fetch("br0", 5'd19);
        check_cw("br0_t3", M_GRA | M_ROUT | M_CONIN);
        cyc();
        check_cw("br0_t4", M_PCOUT | M_YIN);
        cyc();
        check_cw("br0_t5", M_CSIGNOUT | M_ALU_EN | M_ZIN);
        check("br0_t5_aluop", 32'(bus.alu_op), 32'd3);
        cyc();
        check_cw("br0_t6", '0);
        check("br0_t6_run", 32'(bus.run), 32'd1);
        cyc();
        bus.con_ff = 1'b1;
        fetch("br1", 5'd19);
        cyc();
        cyc();
        cyc();
        check_cw("br1_t6", M_ZLOWOUT | M_PCIN);
        cyc();
        bus.con_ff = 1'b0;

        // mul with stop raised mid-instruction
        fetch("mul", 5'd15);
        check_cw("mul_t3", M_GRA | M_ROUT | M_YIN);
        cyc();
        check_cw("mul_t4", M_GRB | M_ROUT | M_ALU_EN | M_ZIN);
        check("mul_t4_aluop", 32'(bus.alu_op), 32'd15);
        bus.stop = 1'b1;
        cyc();
        check_cw("mul_t5", M_ZLOWOUT | M_LOIN);
        cyc();
        check_cw("mul_t6", M_ZHIGHOUT | M_HIIN);
        cyc();
        check_st("paused", 1'b0, 1'b0, 1'b0);
        check_cw("paused_ctrl", '0);
        cyc();
        check("paused_hold_run", 32'(bus.run), 32'd0);
        bus.stop = 1'b0;
        cyc();
        check("resume_run", 32'(bus.run), 32'd1);

        // jal
        fetch("jal", 5'd21);
        check_cw("jal_t3", M_PCOUT | M_GRB | M_RIN);
        cyc();
        check_cw("jal_t4", M_GRA | M_ROUT | M_PCIN);
        cyc();

        // illegal opcode 30
        fetch("ill", 5'd30);
        check_st("ill", 1'b0, 1'b0, 1'b1);
        check_cw("ill_ctrl", '0);
        cyc();
        check("ill_sticky", 32'(bus.fault), 32'd1);
        do_reset();

        // halt
        fetch("halt", 5'd27);
        check_st("halt", 1'b0, 1'b0, 1'b0);
        check_cw("halt_ctrl", '0);
        cyc();
        check("halt_stays", 32'(bus.run), 32'd0);
        do_reset();

        // reset during ld wait at T6
        fetch("ldr", 5'd0);
        cyc();
        cyc();
        bus.mem_ready = 1'b0;
        cyc();
        check_cw("ldr_t6", M_MD_READ | M_MDRIN);
        reset = 1'b0;
        cyc();
        check_cw("ldr_reset_ctrl", '0);
        check("ldr_reset_clear", 32'(bus.clear), 32'd1);
        reset = 1'b1;
        bus.mem_ready = 1'b1;
        cyc();
        check_cw("ldr_after_t0", W_T0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
